rob_ctrl: RTL and testbench
===========================

Name: rob_ctrl

Overview:
In-order allocation/commit controller for the 4-entry reorder buffer that feeds the RAT.
- Accepts dispatched instructions and allocates ROB tags in circular order.
- Issues rename writes to the RAT (rob_addr, dst_addr).
- Records CDB writebacks and retires completed entries strictly in program order, one per cycle.
- Issues a commit write plus RAT release/flush strobes.

Parameters:
DEPTH, 4, number of ROB entries (power of two)
AW, 2, ROB tag width, log2(DEPTH)
RW, 2, architectural register address width (r0..r3)
DW, 16, result value width

Ports:
i_clk  in  1  clock; all logic on rising edge
i_rstn  in  1  synchronous reset, active-low
i_dq_valid  in  1  dispatch queue presents an instruction
i_dq_dst_addr  in  RW  destination architectural register
o_dq_ready  out  1  entry free; dispatch accepted when i_dq_valid & o_dq_ready
o_dq_tag  out  AW  tag to be assigned on accept (current tail)
o_rat_valid  out  1  rename write strobe to RAT
o_rat_rob_addr  out  AW  allocated ROB tag
o_rat_dst_addr  out  RW  renamed architectural register
i_cdb_valid  in  1  execution-unit writeback
i_cdb_tag  in  AW  ROB tag being written back
i_cdb_val  in  DW  result value
o_cmt_valid  out  1  commit strobe to architectural register file / RAT
o_cmt_rob_addr  out  AW  committed tag
o_cmt_dst_addr  out  RW  committed destination register
o_cmt_val  out  DW  committed value
i_flush  in  1  squash all in-flight entries
o_rat_flush  out  1  one-cycle strobe telling RAT to clear all mappings
o_count  out  AW+1  occupied entries, 0..DEPTH
o_empty  out  1  o_count == 0

Behaviour:
- Clock is i_clk. Reset is synchronous and active-low on i_rstn; polarity and synchronicity are fixed.
- State per entry: valid, done, dst[RW], val[DW]. Global state: head[AW], tail[AW], count[AW+1].
- Reset (i_rstn=0 at a rising edge): all valid/done=0; head=tail=count=0; every registered output 0 (o_rat_*, o_cmt_*, o_rat_flush). Combinational outputs follow from state: o_dq_ready=1, o_empty=1, o_dq_tag=0.
- o_dq_ready = (count != DEPTH), decoded from registers only. There is no same-cycle bypass: a full ROB refuses dispatch even if a commit happens that cycle.
- Accept in cycle N:
  - entry[tail] gets valid=1, done=0, dst=i_dq_dst_addr.
  - tail increments, wrapping modulo DEPTH.
  - In cycle N+1: o_rat_valid=1, o_rat_rob_addr=old tail, o_rat_dst_addr=dst. Otherwise o_rat_valid=0.
- CDB in cycle C:
  - If entry[i_cdb_tag] is valid and not done: done=1, val=i_cdb_val.
  - A write to an invalid or already-done entry is ignored. No error flag.
- Commit:
  - In any cycle where entry[head] is valid and done in registers, that entry is freed (valid=0, done=0) and head increments with wrap.
  - Next cycle: o_cmt_valid=1 with that entry's tag, dst and val. At most one commit per cycle.
  - Latency: CDB at cycle C gives o_cmt_valid at C+2 when the entry is at head.
- count: +1 on accept only, -1 on commit only, unchanged when both or neither occur. Accept and commit in the same cycle is legal when not full.
- CDB to the head entry in the same cycle as a commit decision: the decision uses pre-edge done, so commit waits one cycle.
- Flush (i_flush=1 at an edge):
  - Highest priority; overrides same-cycle accept, CDB and commit.
  - All entries invalidated; head=tail=count=0.
  - Next cycle: o_rat_flush=1, o_rat_valid=0, o_cmt_valid=0.
  - Consecutive flush cycles each produce an o_rat_flush pulse.
- Reset mid-operation: identical to flush for state. o_rat_flush is 0 after reset.
- Pointer wrap: head/tail are AW bits. Full vs. empty is resolved only by count.

Decomposition:
- Shared package rob_pkg:
  - DEPTH, AW, RW, DW constants
  - rob_entry_t typedef {valid, done, dst, val}
  - tag_t and areg_t typedefs
- One natural sub-module, rob_entry_array:
  - DEPTH×rob_entry_t storage
  - alloc, CDB and free write ports
  - combinational head-entry read
- Pointer, count, output registers and flush priority stay in rob_ctrl.

Test Plan:
- Reset, then dispatch dst r0, r0, r3 on consecutive cycles -> o_rat_valid pulses with (rob0,r0), (rob1,r0), (rob2,r3) one cycle after each accept; o_count=3.
- CDB tag2=0x0022, then tag0=0x0011 -> single commit (rob0,r0,0x0011) two cycles after the tag0 CDB; rob2 not committed. CDB tag1=0x00AA -> commits rob1 then rob2 (r3,0x0022) on consecutive cycles; o_empty=1.
- Dispatch 4 with no CDB -> o_dq_ready=0, o_count=4; fifth i_dq_valid held with no o_rat_valid; CDB tag0 -> ready returns the cycle after commit of rob0; held dispatch gets tag 0 (wrap).
- CDB to an invalid tag, and a repeat CDB to a done tag with a new value -> no state change; the later commit shows the first value.
- Three entries in flight, i_flush asserted with simultaneous i_dq_valid and CDB -> next cycle o_rat_flush=1, o_count=0, no o_rat_valid or o_cmt_valid; next dispatch gets tag 0.
- i_rstn=0 for one edge with two entries outstanding -> all outputs 0, o_dq_ready=1, o_dq_tag=0; prior CDB tags ignored afterwards.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared types and sizing for the reorder-buffer controller.
// Imported by the interface, the entry array and the top.
package rob_pkg;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);
  localparam int RW    = 2;
  localparam int DW    = 16;

  typedef logic [AW-1:0] tag_t;
  typedef logic [RW-1:0] areg_t;
  typedef logic [AW:0]   cnt_t;
  typedef logic [DW-1:0] val_t;

  typedef struct packed {
    logic  valid;
    logic  done;
    areg_t dst;
    val_t  val;
  } rob_entry_t;
endpackage

// File: rtl/rob_ctrl_if.sv
// Dispatch, rename, writeback, commit and flush bundle of rob_ctrl.
// slave = controller side, master = dispatch/execute/RAT side.
interface rob_ctrl_if;
  import rob_pkg::*;

  logic  i_dq_valid;
  areg_t i_dq_dst_addr;
  logic  o_dq_ready;
  tag_t  o_dq_tag;
  logic  o_rat_valid;
  tag_t  o_rat_rob_addr;
  areg_t o_rat_dst_addr;
  logic  i_cdb_valid;
  tag_t  i_cdb_tag;
  val_t  i_cdb_val;
  logic  o_cmt_valid;
  tag_t  o_cmt_rob_addr;
  areg_t o_cmt_dst_addr;
  val_t  o_cmt_val;
  logic  i_flush;
  logic  o_rat_flush;
  cnt_t  o_count;
  logic  o_empty;

  modport slave (
    input  i_dq_valid, i_dq_dst_addr,
    output o_dq_ready, o_dq_tag,
    output o_rat_valid, o_rat_rob_addr, o_rat_dst_addr,
    input  i_cdb_valid, i_cdb_tag, i_cdb_val,
    output o_cmt_valid, o_cmt_rob_addr, o_cmt_dst_addr, o_cmt_val,
    input  i_flush,
    output o_rat_flush, o_count, o_empty
  );

  modport master (
    output i_dq_valid, i_dq_dst_addr,
    input  o_dq_ready, o_dq_tag,
    input  o_rat_valid, o_rat_rob_addr, o_rat_dst_addr,
    output i_cdb_valid, i_cdb_tag, i_cdb_val,
    input  o_cmt_valid, o_cmt_rob_addr, o_cmt_dst_addr, o_cmt_val,
    output i_flush,
    input  o_rat_flush, o_count, o_empty
  );
endinterface

// File: rtl/rob_entry_array.sv
// ROB entry storage: alloc, CDB and free write ports, head read.
// CDB updates are qualified by pre-edge valid/done state.
module rob_entry_array
  import rob_pkg::*;
(
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       clr_i,
  input  logic       alloc_i,
  input  tag_t       alloc_tag_i,
  input  areg_t      alloc_dst_i,
  input  logic       cdb_i,
  input  tag_t       cdb_tag_i,
  input  val_t       cdb_val_i,
  input  logic       free_i,
  input  tag_t       head_tag_i,
  output rob_entry_t head_o
);

  rob_entry_t [DEPTH-1:0] ent_q;
  rob_entry_t [DEPTH-1:0] ent_d;

  always_comb begin
    ent_d = ent_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (cdb_i && cdb_tag_i == tag_t'(i) &&
          ent_q[i].valid && !ent_q[i].done) begin
        ent_d[i].done = 1'b1;
        ent_d[i].val  = cdb_val_i;
      end
      if (free_i && head_tag_i == tag_t'(i)) begin
        ent_d[i].valid = 1'b0;
        ent_d[i].done  = 1'b0;
      end
      if (alloc_i && alloc_tag_i == tag_t'(i)) begin
        ent_d[i].valid = 1'b1;
        ent_d[i].done  = 1'b0;
        ent_d[i].dst   = alloc_dst_i;
      end
      if (clr_i) begin
        ent_d[i].valid = 1'b0;
        ent_d[i].done  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) ent_q <= '0;
    else         ent_q <= ent_d;
  end

  assign head_o = ent_q[head_tag_i];

endmodule

// File: rtl/rob_ctrl.sv
// In-order allocate/commit controller for the 4-entry ROB.
// Flush outranks accept, CDB and commit in the same cycle.
module rob_ctrl
  import rob_pkg::*;
(
  input logic      i_clk,
  input logic      i_rstn,
  rob_ctrl_if.slave bus
);

  tag_t  head_q, head_d;
  tag_t  tail_q, tail_d;
  cnt_t  count_q, count_d;
  logic  rat_valid_q, rat_valid_d;
  tag_t  rat_addr_q, rat_addr_d;
  areg_t rat_dst_q, rat_dst_d;
  logic  cmt_valid_q, cmt_valid_d;
  tag_t  cmt_addr_q, cmt_addr_d;
  areg_t cmt_dst_q, cmt_dst_d;
  val_t  cmt_val_q, cmt_val_d;
  logic  flush_q, flush_d;

  rob_entry_t head_e;
  logic       ready;
  logic       accept;
  logic       commit;

  assign ready  = (count_q != cnt_t'(DEPTH));
  assign accept = bus.i_dq_valid & ready;
  assign commit = head_e.valid & head_e.done;

  rob_entry_array u_arr (
    .clk_i       (i_clk),
    .rstn_i      (i_rstn),
    .clr_i       (bus.i_flush),
    .alloc_i     (accept & ~bus.i_flush),
    .alloc_tag_i (tail_q),
    .alloc_dst_i (bus.i_dq_dst_addr),
    .cdb_i       (bus.i_cdb_valid & ~bus.i_flush),
    .cdb_tag_i   (bus.i_cdb_tag),
    .cdb_val_i   (bus.i_cdb_val),
    .free_i      (commit & ~bus.i_flush),
    .head_tag_i  (head_q),
    .head_o      (head_e)
  );

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    rat_valid_d = 1'b0;
    rat_addr_d  = rat_addr_q;
    rat_dst_d   = rat_dst_q;
    cmt_valid_d = 1'b0;
    cmt_addr_d  = cmt_addr_q;
    cmt_dst_d   = cmt_dst_q;
    cmt_val_d   = cmt_val_q;
    flush_d     = 1'b0;
    if (bus.i_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      flush_d = 1'b1;
    end else begin
      if (accept) begin
        tail_d      = tail_q + tag_t'(1);
        rat_valid_d = 1'b1;
        rat_addr_d  = tail_q;
        rat_dst_d   = bus.i_dq_dst_addr;
      end
      if (commit) begin
        head_d      = head_q + tag_t'(1);
        cmt_valid_d = 1'b1;
        cmt_addr_d  = head_q;
        cmt_dst_d   = head_e.dst;
        cmt_val_d   = head_e.val;
      end
      unique case ({accept, commit})
        2'b10:   count_d = count_q + cnt_t'(1);
        2'b01:   count_d = count_q - cnt_t'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      rat_valid_q <= 1'b0;
      rat_addr_q  <= '0;
      rat_dst_q   <= '0;
      cmt_valid_q <= 1'b0;
      cmt_addr_q  <= '0;
      cmt_dst_q   <= '0;
      cmt_val_q   <= '0;
      flush_q     <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      rat_valid_q <= rat_valid_d;
      rat_addr_q  <= rat_addr_d;
      rat_dst_q   <= rat_dst_d;
      cmt_valid_q <= cmt_valid_d;
      cmt_addr_q  <= cmt_addr_d;
      cmt_dst_q   <= cmt_dst_d;
      cmt_val_q   <= cmt_val_d;
      flush_q     <= flush_d;
    end
  end

  assign bus.o_dq_ready     = ready;
  assign bus.o_dq_tag       = tail_q;
  assign bus.o_rat_valid    = rat_valid_q;
  assign bus.o_rat_rob_addr = rat_addr_q;
  assign bus.o_rat_dst_addr = rat_dst_q;
  assign bus.o_cmt_valid    = cmt_valid_q;
  assign bus.o_cmt_rob_addr = cmt_addr_q;
  assign bus.o_cmt_dst_addr = cmt_dst_q;
  assign bus.o_cmt_val      = cmt_val_q;
  assign bus.o_rat_flush    = flush_q;
  assign bus.o_count        = count_q;
  assign bus.o_empty        = (count_q == '0);

endmodule

// File: tb/tb_rob_ctrl.sv
// Directed bench for rob_ctrl: rename, ordered commit, full/wrap,
// CDB filtering, flush and mid-run reset.
module tb_rob_ctrl;
  import rob_pkg::*;

  logic clk;
  logic rstn;
  int   tests;
  int   fails;

  rob_ctrl_if bus ();

  rob_ctrl dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_dq_valid    = 1'b0;
    bus.i_dq_dst_addr = '0;
    bus.i_cdb_valid   = 1'b0;
    bus.i_cdb_tag     = '0;
    bus.i_cdb_val     = '0;
    bus.i_flush       = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (bus.o_rat_valid !== 1'b0) begin fails++; $display("FAIL rst_rat_valid got %0h exp 0", bus.o_rat_valid); end
    tests++; if (bus.o_cmt_valid !== 1'b0) begin fails++; $display("FAIL rst_cmt_valid got %0h exp 0", bus.o_cmt_valid); end
    tests++; if (bus.o_rat_flush !== 1'b0) begin fails++; $display("FAIL rst_rat_flush got %0h exp 0", bus.o_rat_flush); end
    tests++; if (bus.o_dq_ready !== 1'b1) begin fails++; $display("FAIL rst_ready got %0h exp 1", bus.o_dq_ready); end
    tests++; if (bus.o_empty !== 1'b1) begin fails++; $display("FAIL rst_empty got %0h exp 1", bus.o_empty); end
    tests++; if (bus.o_dq_tag !== 2'd0) begin fails++; $display("FAIL rst_tag got %0h exp 0", bus.o_dq_tag); end
    tests++; if (bus.o_count !== 3'd0) begin fails++; $display("FAIL rst_count got %0h exp 0", bus.o_count); end
  endtask

  task automatic test_dispatch();
    logic [1:0] dsts [3];
    dsts[0] = 2'd0; dsts[1] = 2'd0; dsts[2] = 2'd3;
    for (int i = 0; i < 3; i++) begin
      bus.i_dq_valid = 1'b1;
      bus.i_dq_dst_addr = dsts[i];
      tick();
      tests++; if ({bus.o_rat_valid, bus.o_rat_rob_addr, bus.o_rat_dst_addr} !== {1'b1, 2'(i), dsts[i]})
        begin fails++; $display("FAIL disp_rat%0d got %0h/%0h/%0h exp 1/%0h/%0h", i, bus.o_rat_valid, bus.o_rat_rob_addr, bus.o_rat_dst_addr, i, dsts[i]); end
    end
    bus.i_dq_valid = 1'b0;
    tick();
    tests++; if (bus.o_rat_valid !== 1'b0) begin fails++; $display("FAIL disp_rat_idle got %0h exp 0", bus.o_rat_valid); end
    tests++; if (bus.o_count !== 3'd3) begin fails++; $display("FAIL disp_count got %0h exp 3", bus.o_count); end
  endtask

  task automatic test_commit_order();
    bus.i_cdb_valid = 1'b1; bus.i_cdb_tag = 2'd2; bus.i_cdb_val = 16'h0022;
    tick();
    tests++; if (bus.o_cmt_valid !== 1'b0) begin fails++; $display("FAIL co_early got %0h exp 0", bus.o_cmt_valid); end
    bus.i_cdb_tag = 2'd0; bus.i_cdb_val = 16'h0011;
    tick();
    bus.i_cdb_valid = 1'b0;
    tests++; if (bus.o_cmt_valid !== 1'b0) begin fails++; $display("FAIL co_c1 got %0h exp 0", bus.o_cmt_valid); end
    tick();
    tests++; if ({bus.o_cmt_valid, bus.o_cmt_rob_addr, bus.o_cmt_dst_addr, bus.o_cmt_val} !== {1'b1, 2'd0, 2'd0, 16'h0011})
      begin fails++; $display("FAIL co_rob0 got %0h/%0h/%0h/%0h exp 1/0/0/11", bus.o_cmt_valid, bus.o_cmt_rob_addr, bus.o_cmt_dst_addr, bus.o_cmt_val); end
    tick();
    tests++; if (bus.o_cmt_valid !== 1'b0) begin fails++; $display("FAIL co_rob2_held got %0h exp 0", bus.o_cmt_valid); end
    tests++; if (bus.o_count !== 3'd2) begin fails++; $display("FAIL co_count2 got %0h exp 2", bus.o_count); end
    bus.i_cdb_valid = 1'b1; bus.i_cdb_tag = 2'd1; bus.i_cdb_val = 16'h00AA;
    tick();
    bus.i_cdb_valid = 1'b0;
    tick();
    tests++; if ({bus.o_cmt_valid, bus.o_cmt_rob_addr, bus.o_cmt_dst_addr, bus.o_cmt_val} !== {1'b1, 2'd1, 2'd0, 16'h00AA})
      begin fails++; $display("FAIL co_rob1 got %0h/%0h/%0h/%0h exp 1/1/0/aa", bus.o_cmt_valid, bus.o_cmt_rob_addr, bus.o_cmt_dst_addr, bus.o_cmt_val); end
    tick();
    tests++; if ({bus.o_cmt_valid, bus.o_cmt_rob_addr, bus.o_cmt_dst_addr, bus.o_cmt_val} !== {1'b1, 2'd2, 2'd3, 16'h0022})
      begin fails++; $display("FAIL co_rob2 got %0h/%0h/%0h/%0h exp 1/2/3/22", bus.o_cmt_valid, bus.o_cmt_rob_addr, bus.o_cmt_dst_addr, bus.o_cmt_val); end
    tick();
    tests++; if (bus.o_cmt_valid !== 1'b0) begin fails++; $display("FAIL co_done got %0h exp 0", bus.o_cmt_valid); end
    tests++; if (bus.o_empty !== 1'b1) begin fails++; $display("FAIL co_empty got %0h exp 1", bus.o_empty); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.i_dq_valid = 1'b1;
      bus.i_dq_dst_addr = 2'(i + 1);
      tick();
    end
    tests++; if (bus.o_count !== 3'd4) begin fails++; $display("FAIL fw_count4 got %0h exp 4", bus.o_count); end
    tests++; if (bus.o_dq_ready !== 1'b0) begin fails++; $display("FAIL fw_ready0 got %0h exp 0", bus.o_dq_ready); end
    tests++; if ({bus.o_rat_valid, bus.o_rat_rob_addr} !== {1'b1, 2'd3}) begin fails++; $display("FAIL fw_last_rat got %0h/%0h exp 1/3", bus.o_rat_valid, bus.o_rat_rob_addr); end
    bus.i_dq_dst_addr = 2'd2;
    bus.i_cdb_valid = 1'b1; bus.i_cdb_tag = 2'd0; bus.i_cdb_val = 16'h0055;
    tick();
    bus.i_cdb_valid = 1'b0;
    tests++; if (bus.o_rat_valid !== 1'b0) begin fails++; $display("FAIL fw_held got %0h exp 0", bus.o_rat_valid); end
    tests++; if (bus.o_dq_ready !== 1'b0) begin fails++; $display("FAIL fw_ready_held got %0h exp 0", bus.o_dq_ready); end
    tick();
    tests++; if ({bus.o_cmt_valid, bus.o_cmt_rob_addr, bus.o_cmt_val} !== {1'b1, 2'd0, 16'h0055})
      begin fails++; $display("FAIL fw_cmt0 got %0h/%0h/%0h exp 1/0/55", bus.o_cmt_valid, bus.o_cmt_rob_addr, bus.o_cmt_val); end
    tests++; if (bus.o_rat_valid !== 1'b0) begin fails++; $display("FAIL fw_no_bypass got %0h exp 0", bus.o_rat_valid); end
    tests++; if ({bus.o_dq_ready, bus.o_dq_tag, bus.o_count} !== {1'b1, 2'd0, 3'd3})
      begin fails++; $display("FAIL fw_ready_back got %0h/%0h/%0h exp 1/0/3", bus.o_dq_ready, bus.o_dq_tag, bus.o_count); end
    tick();
    bus.i_dq_valid = 1'b0;
    tests++; if ({bus.o_rat_valid, bus.o_rat_rob_addr, bus.o_rat_dst_addr} !== {1'b1, 2'd0, 2'd2})
      begin fails++; $display("FAIL fw_wrap_rat got %0h/%0h/%0h exp 1/0/2", bus.o_rat_valid, bus.o_rat_rob_addr, bus.o_rat_dst_addr); end
    tests++; if (bus.o_count !== 3'd4) begin fails++; $display("FAIL fw_count_refill got %0h exp 4", bus.o_count); end
  endtask

  task automatic test_cdb_ignore();
    do_reset();
    bus.i_dq_valid = 1'b1; bus.i_dq_dst_addr = 2'd1;
    tick();
    bus.i_dq_dst_addr = 2'd2;
    tick();
    bus.i_dq_valid = 1'b0;
    bus.i_cdb_valid = 1'b1; bus.i_cdb_tag = 2'd3; bus.i_cdb_val = 16'hDEAD;
    tick();
    bus.i_cdb_tag = 2'd1; bus.i_cdb_val = 16'h0101;
    tick();
    bus.i_cdb_val = 16'h0202;
    tick();
    tests++; if (bus.o_cmt_valid !== 1'b0) begin fails++; $display("FAIL ci_no_cmt got %0h exp 0", bus.o_cmt_valid); end
    tests++; if (bus.o_count !== 3'd2) begin fails++; $display("FAIL ci_count got %0h exp 2", bus.o_count); end
    bus.i_cdb_tag = 2'd0; bus.i_cdb_val = 16'h0303;
    tick();
    bus.i_cdb_valid = 1'b0;
    tick();
    tests++; if ({bus.o_cmt_valid, bus.o_cmt_rob_addr, bus.o_cmt_dst_addr, bus.o_cmt_val} !== {1'b1, 2'd0, 2'd1, 16'h0303})
      begin fails++; $display("FAIL ci_rob0 got %0h/%0h/%0h/%0h exp 1/0/1/303", bus.o_cmt_valid, bus.o_cmt_rob_addr, bus.o_cmt_dst_addr, bus.o_cmt_val); end
    tick();
    tests++; if ({bus.o_cmt_valid, bus.o_cmt_rob_addr, bus.o_cmt_dst_addr, bus.o_cmt_val} !== {1'b1, 2'd1, 2'd2, 16'h0101})
      begin fails++; $display("FAIL ci_rob1_first got %0h/%0h/%0h/%0h exp 1/1/2/101", bus.o_cmt_valid, bus.o_cmt_rob_addr, bus.o_cmt_dst_addr, bus.o_cmt_val); end
    tick();
    tests++; if ({bus.o_cmt_valid, bus.o_empty} !== 2'b01) begin fails++; $display("FAIL ci_drained got %0h/%0h exp 0/1", bus.o_cmt_valid, bus.o_empty); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.i_dq_valid = 1'b1; bus.i_dq_dst_addr = 2'd1;
    tick();
    bus.i_dq_dst_addr = 2'd2;
    bus.i_cdb_valid = 1'b1; bus.i_cdb_tag = 2'd0; bus.i_cdb_val = 16'h0044;
    tick();
    bus.i_cdb_valid = 1'b0;
    bus.i_dq_dst_addr = 2'd3;
    tick();
    bus.i_dq_valid = 1'b0;
    tests++; if ({bus.o_cmt_valid, bus.o_cmt_rob_addr, bus.o_cmt_val} !== {1'b1, 2'd0, 16'h0044})
      begin fails++; $display("FAIL bb_cmt got %0h/%0h/%0h exp 1/0/44", bus.o_cmt_valid, bus.o_cmt_rob_addr, bus.o_cmt_val); end
    tests++; if ({bus.o_rat_valid, bus.o_rat_rob_addr, bus.o_rat_dst_addr} !== {1'b1, 2'd2, 2'd3})
      begin fails++; $display("FAIL bb_rat got %0h/%0h/%0h exp 1/2/3", bus.o_rat_valid, bus.o_rat_rob_addr, bus.o_rat_dst_addr); end
    tests++; if (bus.o_count !== 3'd2) begin fails++; $display("FAIL bb_count got %0h exp 2", bus.o_count); end
  endtask

  task automatic test_flush();
    do_reset();
    bus.i_dq_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.i_dq_dst_addr = 2'(i);
      tick();
    end
    bus.i_dq_valid = 1'b0;
    bus.i_cdb_valid = 1'b1; bus.i_cdb_tag = 2'd0; bus.i_cdb_val = 16'h0077;
    tick();
    bus.i_flush = 1'b1;
    bus.i_dq_valid = 1'b1; bus.i_dq_dst_addr = 2'd3;
    bus.i_cdb_tag = 2'd1; bus.i_cdb_val = 16'h0088;
    tick();
    bus.i_dq_valid = 1'b0; bus.i_cdb_valid = 1'b0;
    tests++; if (bus.o_rat_flush !== 1'b1) begin fails++; $display("FAIL fl_pulse got %0h exp 1", bus.o_rat_flush); end
    tests++; if ({bus.o_rat_valid, bus.o_cmt_valid} !== 2'b00) begin fails++; $display("FAIL fl_quiet got %0h/%0h exp 0/0", bus.o_rat_valid, bus.o_cmt_valid); end
    tests++; if ({bus.o_count, bus.o_empty, bus.o_dq_ready, bus.o_dq_tag} !== {3'd0, 1'b1, 1'b1, 2'd0})
      begin fails++; $display("FAIL fl_state got %0h/%0h/%0h/%0h exp 0/1/1/0", bus.o_count, bus.o_empty, bus.o_dq_ready, bus.o_dq_tag); end
    tick();
    bus.i_flush = 1'b0;
    tests++; if (bus.o_rat_flush !== 1'b1) begin fails++; $display("FAIL fl_second got %0h exp 1", bus.o_rat_flush); end
    bus.i_dq_valid = 1'b1; bus.i_dq_dst_addr = 2'd1;
    tick();
    bus.i_dq_valid = 1'b0;
    tests++; if (bus.o_rat_flush !== 1'b0) begin fails++; $display("FAIL fl_drop got %0h exp 0", bus.o_rat_flush); end
    tests++; if ({bus.o_rat_valid, bus.o_rat_rob_addr, bus.o_rat_dst_addr} !== {1'b1, 2'd0, 2'd1})
      begin fails++; $display("FAIL fl_tag0 got %0h/%0h/%0h exp 1/0/1", bus.o_rat_valid, bus.o_rat_rob_addr, bus.o_rat_dst_addr); end
    tick();
    tests++; if (bus.o_cmt_valid !== 1'b0) begin fails++; $display("FAIL fl_no_stale_cmt got %0h exp 0", bus.o_cmt_valid); end
  endtask

  task automatic test_reset_mid();
    bus.i_dq_valid = 1'b1; bus.i_dq_dst_addr = 2'd2;
    tick();
    bus.i_dq_valid = 1'b1; bus.i_dq_dst_addr = 2'd3;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    bus.i_dq_valid = 1'b0;
    tests++; if ({bus.o_rat_valid, bus.o_rat_rob_addr, bus.o_rat_dst_addr} !== 5'd0)
      begin fails++; $display("FAIL rm_rat got %0h/%0h/%0h exp 0/0/0", bus.o_rat_valid, bus.o_rat_rob_addr, bus.o_rat_dst_addr); end
    tests++; if ({bus.o_cmt_valid, bus.o_cmt_rob_addr, bus.o_cmt_dst_addr, bus.o_cmt_val} !== 21'd0)
      begin fails++; $display("FAIL rm_cmt got %0h/%0h/%0h/%0h exp 0/0/0/0", bus.o_cmt_valid, bus.o_cmt_rob_addr, bus.o_cmt_dst_addr, bus.o_cmt_val); end
    tests++; if ({bus.o_rat_flush, bus.o_dq_ready, bus.o_dq_tag, bus.o_count} !== {1'b0, 1'b1, 2'd0, 3'd0})
      begin fails++; $display("FAIL rm_state got %0h/%0h/%0h/%0h exp 0/1/0/0", bus.o_rat_flush, bus.o_dq_ready, bus.o_dq_tag, bus.o_count); end
    bus.i_cdb_valid = 1'b1; bus.i_cdb_tag = 2'd0; bus.i_cdb_val = 16'h0099;
    tick();
    bus.i_cdb_tag = 2'd1;
    tick();
    bus.i_cdb_valid = 1'b0;
    tick();
    tests++; if ({bus.o_cmt_valid, bus.o_count} !== 4'd0) begin fails++; $display("FAIL rm_stale_cdb got %0h/%0h exp 0/0", bus.o_cmt_valid, bus.o_count); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rstn  = 1'b0;
    idle_inputs();
    tick();
    test_reset();
    test_dispatch();
    test_commit_order();
    test_full_wrap();
    test_cdb_ignore();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
